// File: rtl/atm_balance_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : atm_balance_arbiter
// Description : Two-port round-robin arbiter in front of one 64-bit account
//               balance. Each granted transaction is a deposit (saturating)
//               or a withdrawal (rejected when funds are insufficient).
// Revision    : 1.0 - initial release
// ============================================================================
module atm_balance_arbiter #(
  parameter logic [63:0] INIT_BALANCE = 64'd4500,
  parameter int          AMT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [AMT_W-1:0] amt0,
  input  logic             req1,
  input  logic             op1,
  input  logic [AMT_W-1:0] amt1,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic             bal_upd,
  output logic             insuf,
  output logic [63:0]      balance,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             win_q, win_d;     // latched winner index
  logic             op_q, op_d;       // latched operation (1 = withdrawal)
  logic [AMT_W-1:0] amt_q, amt_d;     // latched amount
  logic             last_q, last_d;   // port granted most recently
  logic [63:0]      bal_q, bal_d;
  logic             upd_q, upd_d;
  logic             insuf_q, insuf_d;

  logic [63:0]      amt_ext;
  logic [64:0]      dep_sum;

  assign amt_ext = 64'(amt_q);
  // Extra carry bit detects deposit overflow for saturation.
  assign dep_sum = {1'b0, bal_q} + {1'b0, amt_ext};

  // Next-state, arbitration and balance arithmetic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    op_d    = op_q;
    amt_d   = amt_q;
    last_d  = last_q;
    bal_d   = bal_q;
    upd_d   = upd_q;
    insuf_d = insuf_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_EXEC;
          // On a tie the port that was not granted last wins.
          win_d   = (req0 && req1) ? ~last_q : req1;
          op_d    = win_d ? op1  : op0;
          amt_d   = win_d ? amt1 : amt0;
          last_d  = win_d;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        if (!op_q) begin
          bal_d   = dep_sum[64] ? {64{1'b1}} : dep_sum[63:0];
          upd_d   = 1'b1;
          insuf_d = 1'b0;
        end else if (amt_ext <= bal_q) begin
          bal_d   = bal_q - amt_ext;
          upd_d   = 1'b1;
          insuf_d = 1'b0;
        end else begin
          upd_d   = 1'b0;
          insuf_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      amt_q   <= '0;
      last_q  <= 1'b1;
      bal_q   <= INIT_BALANCE;
      upd_q   <= 1'b0;
      insuf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      last_q  <= last_d;
      bal_q   <= bal_d;
      upd_q   <= upd_d;
      insuf_q <= insuf_d;
    end
  end

  // Outputs decoded from the registered state; status flags gated to RESP.
  always_comb begin
    gnt     = 2'b00;
    ack     = 2'b00;
    bal_upd = 1'b0;
    insuf   = 1'b0;
    if (state_q == S_EXEC) begin
      gnt = win_q ? 2'b10 : 2'b01;
    end
    if (state_q == S_RESP) begin
      ack     = win_q ? 2'b10 : 2'b01;
      bal_upd = upd_q;
      insuf   = insuf_q;
    end
  end

  assign balance = bal_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_atm_balance_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_atm_balance_arbiter
// Description : Table-driven bench for atm_balance_arbiter plus a saturation
//               sequence on a second instance preset near the 64-bit maximum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_balance_arbiter;

  localparam logic [63:0] SAT_INIT = 64'hFFFF_FFFD_0000_0000;

  logic        clk;
  logic        rst, req0, op0, req1, op1;
  logic [31:0] amt0, amt1;
  logic [1:0]  gnt, ack;
  logic        bal_upd, insuf, busy;
  logic [63:0] balance;

  logic        s_rst, s_req0, s_op0, s_req1, s_op1;
  logic [31:0] s_amt0, s_amt1;
  logic [1:0]  s_gnt, s_ack;
  logic        s_bal_upd, s_insuf, s_busy;
  logic [63:0] s_balance;

  int n_checks = 0;
  int n_err    = 0;

  atm_balance_arbiter #(.INIT_BALANCE(64'd4500), .AMT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .amt0(amt0),
    .req1(req1), .op1(op1), .amt1(amt1),
    .gnt(gnt), .ack(ack), .bal_upd(bal_upd), .insuf(insuf),
    .balance(balance), .busy(busy)
  );

  atm_balance_arbiter #(.INIT_BALANCE(SAT_INIT), .AMT_W(32)) u_sat (
    .clk(clk), .rst(s_rst),
    .req0(s_req0), .op0(s_op0), .amt0(s_amt0),
    .req1(s_req1), .op1(s_op1), .amt1(s_amt1),
    .gnt(s_gnt), .ack(s_ack), .bal_upd(s_bal_upd), .insuf(s_insuf),
    .balance(s_balance), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        r0;
    logic        o0;
    logic [31:0] a0;
    logic        r1;
    logic        o1;
    logic [31:0] a1;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        upd;
    logic        ins;
    logic [63:0] bal;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic r0, input logic o0, input logic [31:0] a0,
                     input logic r1, input logic o1, input logic [31:0] a1,
                     input logic [1:0] g, input logic [1:0] k, input logic u,
                     input logic i, input logic [63:0] b, input logic bz);
    vec_t v;
    v.rst = r; v.r0 = r0; v.o0 = o0; v.a0 = a0; v.r1 = r1; v.o1 = o1; v.a1 = a1;
    v.gnt = g; v.ack = k; v.upd = u; v.ins = i; v.bal = b; v.busy = bz;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One saturation-instance deposit on port 0 with full latency checks.
  task automatic sat_dep(input int idx, input logic [31:0] a, input logic [63:0] exp_bal);
    s_req0 = 1'b1; s_op0 = 1'b0; s_amt0 = a;
    @(posedge clk); #1;
    chk("sat_gnt", idx, 64'(s_gnt), 64'd1);
    @(posedge clk); #1;
    chk("sat_ack", idx, 64'(s_ack), 64'd1);
    chk("sat_upd", idx, 64'(s_bal_upd), 64'd1);
    chk("sat_bal", idx, s_balance, exp_bal);
    s_req0 = 1'b0;
    @(posedge clk); #1;
    chk("sat_busy", idx, 64'(s_busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 0; op0 = 0; amt0 = 0; req1 = 0; op1 = 0; amt1 = 0;
    s_rst = 1'b1; s_req0 = 0; s_op0 = 0; s_amt0 = 0; s_req1 = 0; s_op1 = 0; s_amt1 = 0;

    //   rst r0 o0 a0    r1 o1 a1     gnt ack upd ins bal   busy
    // Deposit 500 on port 0; op/amt changes during EXEC are ignored.
    add(1, 0,0,0,     0,0,0,      0,0,0,0, 4500, 0);
    add(0, 1,0,500,   0,0,0,      1,0,0,0, 4500, 1);
    add(0, 1,1,9999,  0,0,0,      0,1,1,0, 5000, 1);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 5000, 0);
    // Withdraw whole balance on port 1, then an insufficient withdrawal of 1.
    add(1, 0,0,0,     0,0,0,      0,0,0,0, 4500, 0);
    add(0, 0,0,0,     1,1,4500,   2,0,0,0, 4500, 1);
    add(0, 0,0,0,     1,1,4500,   0,2,1,0, 0,    1);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 0,    0);
    add(0, 0,0,0,     1,1,1,      2,0,0,0, 0,    1);
    add(0, 0,0,0,     1,1,1,      0,2,0,1, 0,    1);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 0,    0);
    // Tie after reset: port 0 first, port 1 stays pending, acks 3 cycles apart.
    add(1, 0,0,0,     0,0,0,      0,0,0,0, 4500, 0);
    add(0, 1,0,10,    1,0,20,     1,0,0,0, 4500, 1);
    add(0, 1,0,10,    1,0,20,     0,1,1,0, 4510, 1);
    add(0, 0,0,0,     1,0,20,     0,0,0,0, 4510, 0);
    add(0, 0,0,0,     1,0,20,     2,0,0,0, 4510, 1);
    add(0, 0,0,0,     1,0,20,     0,2,1,0, 4530, 1);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 4530, 0);
    // Three consecutive ties: grant order 0, 1, 0.
    add(0, 1,0,1,     1,0,2,      1,0,0,0, 4530, 1);
    add(0, 1,0,1,     1,0,2,      0,1,1,0, 4531, 1);
    add(0, 0,0,0,     1,0,2,      0,0,0,0, 4531, 0);
    add(0, 1,0,1,     1,0,2,      2,0,0,0, 4531, 1);
    add(0, 1,0,1,     1,0,2,      0,2,1,0, 4533, 1);
    add(0, 1,0,1,     0,0,0,      0,0,0,0, 4533, 0);
    add(0, 1,0,1,     1,0,2,      1,0,0,0, 4533, 1);
    add(0, 1,0,1,     1,0,2,      0,1,1,0, 4534, 1);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 4534, 0);
    // Reset in EXEC of a deposit of 100 abandons it with no ack.
    add(1, 0,0,0,     0,0,0,      0,0,0,0, 4500, 0);
    add(0, 1,0,100,   0,0,0,      1,0,0,0, 4500, 1);
    add(1, 1,0,100,   0,0,0,      0,0,0,0, 4500, 0);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 4500, 0);
    // Zero-amount deposit completes with bal_upd and no change.
    add(0, 0,0,0,     1,0,0,      2,0,0,0, 4500, 1);
    add(0, 0,0,0,     1,0,0,      0,2,1,0, 4500, 1);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 4500, 0);
    // Request dropped during EXEC still completes.
    add(0, 1,1,500,   0,0,0,      1,0,0,0, 4500, 1);
    add(0, 0,0,0,     0,0,0,      0,1,1,0, 4000, 1);
    add(0, 0,0,0,     0,0,0,      0,0,0,0, 4000, 0);

    foreach (vq[i]) begin
      rst = vq[i].rst; req0 = vq[i].r0; op0 = vq[i].o0; amt0 = vq[i].a0;
      req1 = vq[i].r1; op1 = vq[i].o1; amt1 = vq[i].a1;
      @(posedge clk); #1;
      chk("gnt",     i, 64'(gnt),     64'(vq[i].gnt));
      chk("ack",     i, 64'(ack),     64'(vq[i].ack));
      chk("bal_upd", i, 64'(bal_upd), 64'(vq[i].upd));
      chk("insuf",   i, 64'(insuf),   64'(vq[i].ins));
      chk("balance", i, balance,      vq[i].bal);
      chk("busy",    i, 64'(busy),    64'(vq[i].busy));
    end

    // Saturation: repeated maximum deposits from a preset near 2^64-1.
    @(posedge clk); #1;
    chk("sat_reset_bal", 0, s_balance, SAT_INIT);
    s_rst = 1'b0;
    sat_dep(1, 32'hFFFF_FFFF, 64'hFFFF_FFFD_FFFF_FFFF);
    sat_dep(2, 32'hFFFF_FFFF, 64'hFFFF_FFFE_FFFF_FFFE);
    sat_dep(3, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD);
    sat_dep(4, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    sat_dep(5, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atm_balance_arbiter.md
ATM_BALANCE_ARBITER -- requirements
Module: atm_balance_arbiter

Interface
REQ-001 Parameter: INIT_BALANCE, 4500, value loaded into the 64-bit account balance on reset.
REQ-002 Parameter: AMT_W, 32, width of the transaction amount inputs.
REQ-003 Port: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req0  input  1  port-0 transaction request; held high until ack0.
REQ-006 Port: op0  input  1  port-0 operation: 0 = deposit, 1 = withdrawal.
REQ-007 Port: amt0  input  AMT_W  port-0 amount, unsigned.
REQ-008 Port: req1, op1, amt1  input  1/1/AMT_W  port-1 equivalents of req0/op0/amt0.
REQ-009 Port: gnt  output  2  one-hot grant; bit i is high while port i's transaction executes.
REQ-010 Port: ack  output  2  one-cycle completion pulse; bit i means port i's transaction is done.
REQ-011 Port: bal_upd  output  1  high with ack when the balance changed.
REQ-012 Port: insuf  output  1  high with ack when a withdrawal was rejected for insufficient funds.
REQ-013 Port: balance  output  64  current registered account balance.
REQ-014 Port: busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP, encoded in a registered state variable with next-state logic.
- IDLE -> EXEC when req0 or req1 is high.
- EXEC -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 In IDLE with a request present, the block SHALL latch the winner index, its op and its amt at that edge; later changes to op/amt SHALL be ignored.
REQ-017 Arbitration SHALL be round-robin via a last-granted pointer.
- Only one request high: that request wins.
- Both high: the port not granted last wins.
- The pointer SHALL update on entry to EXEC.
REQ-018 gnt SHALL be one-hot for the latched winner during EXEC and 0 in all other states.
REQ-019 Deposit at the EXEC->RESP edge: balance <= balance + amt, zero-extended to 64 bits.
- On overflow the balance SHALL saturate at 2^64-1.
- bal_upd SHALL be 1.
REQ-020 Withdrawal at the EXEC->RESP edge:
- If amt <= balance: balance <= balance - amt, bal_upd = 1, insuf = 0. amt equal to balance is accepted and yields 0.
- If amt > balance: balance is unchanged, insuf = 1, bal_upd = 0.
REQ-021 In RESP, ack[winner] SHALL be high for exactly one cycle, together with bal_upd/insuf; all three SHALL be 0 in every other state.
REQ-022 Latency: request sampled at edge k -> gnt high in cycle k+1 -> ack, balance, bal_upd and insuf visible in cycle k+2 -> IDLE in cycle k+3.
REQ-023 A requester SHALL deassert req at the edge after ack.
- A req still high in IDLE is treated as a new transaction.
- Back-to-back service therefore needs at least 3 cycles per transaction.
REQ-024 A request from the losing port SHALL stay pending, with no drop and no ack, until it is served in a later IDLE.
REQ-025 A req that drops during EXEC or RESP SHALL NOT abort the transaction; it completes and acks.
REQ-026 An amt of 0 SHALL complete normally: bal_upd = 1, balance unchanged.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL reset, with rst taking priority over all other inputs:
- state = IDLE, balance = INIT_BALANCE, last-granted pointer = port 1 (so port 0 wins the first tie).
- gnt = 0, ack = 0, bal_upd = 0, insuf = 0, busy = 0.
REQ-028 A reset asserted during EXEC or RESP SHALL abandon the transaction with no ack and no balance change beyond the reset value.

Verification
REQ-029 Reset, then req0 with op0=0 and amt0=500 -> gnt=01 in cycle k+1; in cycle k+2 ack=01, bal_upd=1, balance=5000.
REQ-030 Reset, then req1 with op1=1 and amt1=4500 -> ack=10, bal_upd=1, insuf=0, balance=0; then a withdrawal of 1 -> insuf=1, bal_upd=0, balance=0.
REQ-031 Reset, then req0 and req1 raised on the same edge, each held until its ack -> port 0 is served first (ack=01), port 1 next (ack=10), with 3 cycles between the two acks.
REQ-032 Three consecutive ties -> grant order 0, 1, 0 (round-robin alternation).
REQ-033 Reset asserted in the EXEC cycle of a deposit of 100 -> no ack, balance=4500, state IDLE the next cycle.
REQ-034 Balance preset near 2^64-1 via a repeated maximum deposit (amt0=2^32-1), then one further deposit -> balance=2^64-1 with bal_upd=1.
